// File: rtl/regfile_param.sv
// Parametrised register file: two read ports, one write port, optional
// hardwired zero register, optional write-to-read forwarding, optional
// registered read path, and a sequential clear engine that zeroes every
// entry after reset or on request.
//
// Handshake/timing summary: there is no valid/ready flow control. A write is
// accepted at a rising edge when we=1 and the clear engine is idle; a write
// presented while busy=1 is discarded and flagged by a one-cycle wr_dropped
// pulse. clear is a level sampled only while idle.
module regfile_param #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  localparam int ADDR_W   = $clog2(DEPTH),
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  parameter  bit READ_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  output logic              wr_dropped
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_en;
  logic [WIDTH-1:0]  v1, v2;

  // busy is a pure decode of the state register, so it is glitch-free.
  assign busy = (state == CLEAR);

  // A write lands only when idle; writes to a hardwired entry 0 vanish.
  assign wr_en = we && (state == IDLE) && !(ZERO_REG && (wa == '0));

  // State register and clear pointer; reset restarts the full pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state logic: walk every entry once, then wait for a clear request.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST) state_nxt = IDLE;
      end
      IDLE: begin
        if (clear) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Flag a write that arrived while the clear engine owned the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_dropped <= 1'b0;
    else        wr_dropped <= we && busy;
  end

  // Storage array: clear engine has the write port while busy, else the user.
  always_ff @(posedge clk) begin
    if (busy)       mem[clr_ptr] <= '0;
    else if (wr_en) mem[wa]      <= wd;
  end

  // Read value for port 1: busy, zero register, forwarding, then array.
  always_comb begin
    v1 = mem[ra1];
    if (busy)                              v1 = '0;
    else if (ZERO_REG && (ra1 == '0))      v1 = '0;
    else if (BYPASS && wr_en && (wa == ra1)) v1 = wd;
  end

  // Read value for port 2, same priority as port 1.
  always_comb begin
    v2 = mem[ra2];
    if (busy)                              v2 = '0;
    else if (ZERO_REG && (ra2 == '0))      v2 = '0;
    else if (BYPASS && wr_en && (wa == ra2)) v2 = wd;
  end

  generate
    if (READ_REG) begin : g_read_reg
      // Registered read path: data follows the address by one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd1 <= '0;
          rd2 <= '0;
        end else begin
          rd1 <= v1;
          rd2 <= v2;
        end
      end
    end else begin : g_read_comb
      assign rd1 = v1;
      assign rd2 = v2;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param. Two instances share every input:
//   dut   : defaults (ZERO_REG=1, BYPASS=1, READ_REG=0)
//   dut_b : ZERO_REG=0, BYPASS=0, READ_REG=1
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit
// later, well away from any clock edge.
module tb_regfile_param;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic [ADDR_W-1:0] ra1, ra2, wa;
  logic              we;
  logic [WIDTH-1:0]  wd;

  logic              busy, wr_dropped;
  logic [WIDTH-1:0]  rd1, rd2;
  logic              busy_b, wr_dropped_b;
  logic [WIDTH-1:0]  rd1_b, rd2_b;

  int checks = 0;
  int errors = 0;
  int cycles;

  logic [WIDTH-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .wr_dropped(wr_dropped)
  );

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0),
                  .BYPASS(1'b0), .READ_REG(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_b),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we(we), .wa(wa), .wd(wd), .wr_dropped(wr_dropped_b)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for busy to fall, bounded; returns number of edges seen while busy.
  task automatic wait_idle(input int start, output int n);
    n = start;
    while (busy && n < 200) begin
      clear = (n == 10);  // a clear during the pass must not restart it
      tick();
      n++;
    end
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; we = 1'b0;
    ra1 = '0; ra2 = '0; wa = '0; wd = '0;

    // ---- reset state ----
    repeat (3) tick();
    settle();
    check("reset_busy",       WIDTH'(busy),         32'd1);
    check("reset_busy_b",     WIDTH'(busy_b),       32'd1);
    check("reset_wr_dropped", WIDTH'(wr_dropped),   32'd0);
    check("reset_rd1",        rd1,                  32'd0);
    check("reset_rd1_b",      rd1_b,                32'd0);
    check("reset_rd2_b",      rd2_b,                32'd0);

    // ---- initial clear pass lasts exactly DEPTH cycles ----
    rst_n = 1'b1;
    settle();
    cycles = 0;
    while (busy && cycles < 200) begin
      check("pass_rd1_zero", rd1, 32'd0);
      ra1 = ADDR_W'(cycles);
      tick();
      cycles++;
    end
    check("init_busy_cycles", cycles, 32'd32);
    check("init_busy_b_done", WIDTH'(busy_b), 32'd0);

    // ---- every address reads zero after the pass ----
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = ADDR_W'(i);
      settle();
      check("post_clear_rd1", rd1, 32'd0);
      tick();
      check("post_clear_rd1_b", rd1_b, 32'd0);
    end

    // ---- write / readback ----
    ra1 = '0;
    we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    ra1 = 5'd7;
    settle();
    check("wr7_rd1", rd1, 32'hDEADBEEF);
    check("wr7_rd1_b_latency", rd1_b, 32'd0);
    tick();
    check("wr7_rd1_b", rd1_b, 32'hDEADBEEF);

    // ---- zero register ----
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    tick();
    we = 1'b0;
    ra2 = 5'd0;
    settle();
    check("zero_wr_dropped",   WIDTH'(wr_dropped),   32'd0);
    check("zero_wr_dropped_b", WIDTH'(wr_dropped_b), 32'd0);
    check("zero_rd2", rd2, 32'd0);
    tick();
    check("zero_rd2_b", rd2_b, 32'h1234);

    // ---- bypass ----
    we = 1'b1; wa = 5'd5; wd = 32'h11;
    tick();
    wd = 32'hA5A5A5A5; ra1 = 5'd5; ra2 = 5'd5;
    settle();
    check("bypass_rd1", rd1, 32'hA5A5A5A5);
    check("bypass_rd2_same", rd2, 32'hA5A5A5A5);
    tick();
    we = 1'b0;
    settle();
    check("nobypass_rd1_b", rd1_b, 32'h11);
    check("after_bypass_rd1", rd1, 32'hA5A5A5A5);
    tick();
    check("after_bypass_rd1_b", rd1_b, 32'hA5A5A5A5);
    check("after_bypass_rd2_b", rd2_b, 32'hA5A5A5A5);

    // ---- write during busy, clear ignored during pass ----
    clear = 1'b1;
    tick();
    clear = 1'b0;
    settle();
    check("clear_busy_rise", WIDTH'(busy), 32'd1);
    check("clear_busy_rd1",  rd1,          32'd0);
    we = 1'b1; wa = 5'd3; wd = 32'hFF;
    tick();
    we = 1'b0;
    settle();
    check("busy_wr_dropped",   WIDTH'(wr_dropped),   32'd1);
    check("busy_wr_dropped_b", WIDTH'(wr_dropped_b), 32'd1);
    tick();
    check("busy_wr_dropped_pulse", WIDTH'(wr_dropped), 32'd0);
    wait_idle(2, cycles);
    check("clear_busy_cycles", cycles, 32'd32);

    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    foreach (exp_q[k]) begin
      case (k)
        0: ra1 = 5'd3;
        1: ra1 = 5'd5;
        2: ra1 = 5'd7;
        default: ra1 = 5'd0;
      endcase
      settle();
      check("after_clear_rd1", rd1, exp_q[k]);
      tick();
      check("after_clear_rd1_b", rd1_b, exp_q[k]);
    end
    exp_q.delete();

    // ---- reset mid-clear ----
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    settle();
    check("midrst_busy", WIDTH'(busy), 32'd1);
    tick();
    check("midrst_busy_hold", WIDTH'(busy), 32'd1);
    check("midrst_rd1_b", rd1_b, 32'd0);
    rst_n = 1'b1;
    settle();
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
    check("midrst_busy_cycles", cycles, 32'd32);

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
